uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_if.sv | 34 +++
 rtl/uart_sync.sv | 25 ++
 rtl/uart_rx.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-size defaults and the receiver state encoding.
//   DATA_BITS_DEF  - default data bits per frame
//   OVERSAMPLE_DEF - default baud ticks per bit period
//   rx_state_t     - receiver FSM states
package uart_pkg;

  localparam int unsigned DATA_BITS_DEF  = 8;
  localparam int unsigned OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Host-side receive interface.
//   rx_data       - last accepted byte
//   rx_ready      - rx_data holds an unread byte
//   framing_error - last completed frame had a zero stop bit
//   overrun       - a frame was dropped while rx_ready was set
//   rx_read       - one-clk pop strobe from the host
// master: the receiver; slave: the host.
interface uart_rx_if #(
  parameter int unsigned DATA_BITS = uart_pkg::DATA_BITS_DEF
) ();

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_ready;
  logic                 framing_error;
  logic                 overrun;
  logic                 rx_read;

  modport master (
    output rx_data,
    output rx_ready,
    output framing_error,
    output overrun,
    input  rx_read
  );

  modport slave (
    input  rx_data,
    input  rx_ready,
    input  framing_error,
    input  overrun,
    output rx_read
  );

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
//   clk - clock
//   rst - synchronous active-high reset
//   d   - asynchronous input
//   q   - synchronized output
module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, mid-bit sampling, LSB-first data,
// one stop bit, single-entry holding register with framing/overrun flags.
//   clk          - clock
//   rst          - synchronous active-high reset
//   receive_baud - one-clk pulse at OVERSAMPLE x baud rate
//   rxd          - asynchronous serial line, idle high
//   host         - host-side interface (rx_data/rx_ready/framing_error/overrun/rx_read)
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      receive_baud,
  input  logic      rxd,
  uart_rx_if.master host
);

  localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 rxd_s;
  rx_state_t            state, state_n;
  logic [TICK_W-1:0]    tick_cnt, tick_n;
  logic [BIT_W-1:0]     bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 done_c;

  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_ready_q;
  logic                 framing_error_q;
  logic                 overrun_q;

  uart_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  // State, counters and shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RX_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      shreg    <= shreg_n;
    end
  end

  // Next state; everything except the WAIT_HIGH exit moves only on baud ticks
  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    done_c  = 1'b0;
    case (state)
      RX_IDLE: begin
        if (receive_baud && !rxd_s) begin
          state_n = RX_START;
          tick_n  = '0;
        end
      end
      RX_START: begin
        if (receive_baud) begin
          if (tick_cnt == TICK_HALF) begin
            // Still low at mid start bit: real start; otherwise a glitch
            state_n = rxd_s ? RX_IDLE : RX_DATA;
            tick_n  = '0;
            bit_n   = '0;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (receive_baud) begin
          if (tick_cnt == TICK_LAST) begin
            tick_n  = '0;
            shreg_n = {rxd_s, shreg[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) begin
              state_n = RX_STOP;
              bit_n   = '0;
            end else begin
              bit_n = bit_cnt + 1'b1;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (receive_baud) begin
          if (tick_cnt == TICK_LAST) begin
            done_c  = 1'b1;
            tick_n  = '0;
            state_n = rxd_s ? RX_IDLE : RX_WAIT_HIGH;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      RX_WAIT_HIGH: begin
        // Line held low (break) after a bad stop bit: wait for idle level
        if (rxd_s) begin
          state_n = RX_IDLE;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  // Holding register and host flags; a same-cycle pop frees the slot for the new byte
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q       <= '0;
      rx_ready_q      <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else if (done_c) begin
      if (!rx_ready_q || host.rx_read) begin
        rx_data_q       <= shreg;
        rx_ready_q      <= 1'b1;
        framing_error_q <= !rxd_s;
        overrun_q       <= 1'b0;
      end else begin
        overrun_q <= 1'b1;
      end
    end else if (host.rx_read && rx_ready_q) begin
      rx_ready_q <= 1'b0;
      overrun_q  <= 1'b0;
    end
  end

  assign host.rx_data       = rx_data_q;
  assign host.rx_ready      = rx_ready_q;
  assign host.framing_error = framing_error_q;
  assign host.overrun       = overrun_q;

endmodule
